// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_pkg
// Brief    : Shared types and constants for the IF/MEM memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [31:0] C_ERR_DATA = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Fetch, data and memory handshakes of the shared memory port.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;
    logic            if_err;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;
    logic            d_err;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    logic            bus_err;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output bus_err
    );

    // Pipeline + memory side
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  bus_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_watchdog
// Brief    : Response timer; expire is high on the TIMEOUT-th enabled cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] r_cnt;

    assign expire = en && (r_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Serialises IF fetches and MEM loads/stores onto one memory port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int            AW           = 32,
    parameter int            DW           = 32,
    parameter int            STARVE_LIMIT = 4,
    parameter int            TIMEOUT      = 16,
    parameter logic [DW-1:0] ERR_DATA     = DW'(C_ERR_DATA)
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e      r_state, w_state_nxt;
    owner_e          r_owner, w_owner_nxt;
    logic [SW-1:0]   r_starve, w_starve_nxt;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW/8-1:0] r_be;
    logic [DW-1:0]   r_rdata;
    logic            r_err;
    logic            r_bus_err;
    logic            w_latch, w_pick_d, w_expire, w_tmr_clr, w_tmr_en;
    logic            w_resp_if, w_resp_d;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_tmr_clr),
        .en     (w_tmr_en),
        .expire (w_expire)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_starve_nxt = r_starve;
        w_latch      = 1'b0;
        w_pick_d     = 1'b0;
        w_tmr_clr    = 1'b0;
        w_tmr_en     = 1'b0;
        case (r_state)
            IDLE: begin
                // Data is the older instruction, unless fetch has waited too long
                w_pick_d = bus.d_req && !(bus.if_req && (r_starve == SW'(STARVE_LIMIT)));
                if (bus.d_req || bus.if_req) begin
                    w_latch     = 1'b1;
                    w_state_nxt = REQ;
                    w_owner_nxt = w_pick_d ? OWN_D : OWN_IF;
                end
                if (!bus.if_req || !w_pick_d) begin
                    w_starve_nxt = '0;
                end else if (r_starve != SW'(STARVE_LIMIT)) begin
                    w_starve_nxt = r_starve + 1'b1;
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_tmr_en = 1'b1;
                if (bus.mem_rvalid || w_expire) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_owner   <= OWN_IF;
            r_starve  <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_starve <= w_starve_nxt;
            if (w_latch) begin
                r_we    <= w_pick_d ? bus.d_we    : 1'b0;
                r_addr  <= w_pick_d ? bus.d_addr  : bus.if_addr;
                r_wdata <= w_pick_d ? bus.d_wdata : '0;
                r_be    <= w_pick_d ? bus.d_be    : '1;
            end
            // A response arriving with the timeout still counts as a normal one
            if (r_state == WAIT) begin
                if (bus.mem_rvalid) begin
                    r_rdata <= r_we ? '0 : bus.mem_rdata;
                    r_err   <= 1'b0;
                end else if (w_expire) begin
                    r_rdata <= ERR_DATA;
                    r_err   <= 1'b1;
                end
            end
            if ((r_state == WAIT && !bus.mem_rvalid && w_expire) ||
                (r_state != WAIT && bus.mem_rvalid)) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign w_resp_if = (r_state == RESP) && (r_owner == OWN_IF);
    assign w_resp_d  = (r_state == RESP) && (r_owner == OWN_D);

    assign bus.mem_req   = (r_state == REQ);
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_be    = r_be;

    assign bus.if_gnt    = (r_state == REQ) && (r_owner == OWN_IF) && bus.mem_gnt;
    assign bus.if_rvalid = w_resp_if;
    assign bus.if_rdata  = w_resp_if ? r_rdata : '0;
    assign bus.if_err    = w_resp_if && r_err;

    assign bus.d_gnt     = (r_state == REQ) && (r_owner == OWN_D) && bus.mem_gnt;
    assign bus.d_rvalid  = w_resp_d;
    assign bus.d_rdata   = w_resp_d ? r_rdata : '0;
    assign bus.d_err     = w_resp_d && r_err;

    assign bus.bus_err   = r_bus_err;
endmodule
`default_nettype wire
